// File: rtl/sram_write_ctrl_if.sv
// Byte-stream and SRAM write-port bundle for sram_write_ctrl.
// timeout_err exists only when LOAD_TIMEOUT_EN is defined.
interface sram_write_ctrl_if #(
  parameter int ADDR_W = 4
);
  logic              start_in;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              sram_cs_n;
  logic              sram_we_n;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic              busy;
  logic              load_done;
  logic              clk_end;
`ifdef LOAD_TIMEOUT_EN
  logic              timeout_err;
`endif

  modport master (
    output start_in, in_valid, in_data,
    input  in_ready, sram_cs_n, sram_we_n,
    input  sram_addr, sram_wdata,
    input  busy, load_done, clk_end
`ifdef LOAD_TIMEOUT_EN
    , input timeout_err
`endif
  );

  modport slave (
    input  start_in, in_valid, in_data,
    output in_ready, sram_cs_n, sram_we_n,
    output sram_addr, sram_wdata,
    output busy, load_done, clk_end
`ifdef LOAD_TIMEOUT_EN
    , output timeout_err
`endif
  );
endinterface

// File: rtl/sram_write_ctrl.sv
// Packs 4 bytes per word and writes NUM_WORDS words to SRAM.
// Define LOAD_TIMEOUT_EN to abort a stalled LOAD after TIMEOUT cycles.
module sram_write_ctrl #(
  parameter int NUM_WORDS = 16,
  parameter int ADDR_W    = 4,
  parameter int TIMEOUT   = 255
) (
  input logic             clk_i,
  input logic             rst,
  sram_write_ctrl_if.slave bus
);

  if (NUM_WORDS > (1 << ADDR_W) || NUM_WORDS < 1 || TIMEOUT < 1)
  begin : g_bad_cfg
    $error("sram_write_ctrl: bad parameters");
  end

  typedef enum logic [1:0] {
    IDLE, LOAD, WRITE, DONE
  } state_e;

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(NUM_WORDS - 1);

  state_e            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       word_q, word_d;
  logic              in_ready_q, in_ready_d;
  logic              cs_n_q, cs_n_d;
  logic              we_n_q, we_n_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              clk_end_q, clk_end_d;
  logic              accept;

`ifdef LOAD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] idle_q, idle_d;
  logic          terr_q, terr_d;
  logic          abort;
`endif

  assign accept = bus.in_valid & in_ready_q;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    addr_d     = addr_q;
    word_d     = word_q;
`ifdef LOAD_TIMEOUT_EN
    idle_d     = idle_q;
    terr_d     = terr_q;
    abort      = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start_in) begin
          state_d    = LOAD;
          byte_cnt_d = '0;
          addr_d     = '0;
          word_d     = '0;
`ifdef LOAD_TIMEOUT_EN
          idle_d     = '0;
          terr_d     = 1'b0;
`endif
        end
      end
      LOAD: begin
        if (accept) begin
          word_d[{byte_cnt_q, 3'b000} +: 8] = bus.in_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = WRITE;
`ifdef LOAD_TIMEOUT_EN
          idle_d = '0;
        end else if (idle_q == CW'(TIMEOUT - 1)) begin
          // stalled producer: drop the partial load
          state_d = IDLE;
          idle_d  = '0;
          terr_d  = 1'b1;
          abort   = 1'b1;
        end else begin
          idle_d = idle_q + CW'(1);
`endif
        end
      end
      WRITE: begin
        if (addr_q == LAST) begin
          state_d = DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = LOAD;
        end
      end
      DONE: state_d = IDLE;
    endcase

    // outputs are registered from the next state
    in_ready_d  = (state_d == LOAD);
    cs_n_d      = (state_d != WRITE);
    we_n_d      = (state_d != WRITE);
    sram_addr_d = (state_d == WRITE) ? addr_q : '0;
    wdata_d     = (state_d == WRITE) ? word_d : '0;
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
`ifdef LOAD_TIMEOUT_EN
    clk_end_d   = (state_d == DONE) | abort;
`else
    clk_end_d   = (state_d == DONE);
`endif
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      byte_cnt_q  <= '0;
      addr_q      <= '0;
      word_q      <= '0;
      in_ready_q  <= 1'b0;
      cs_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      sram_addr_q <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      clk_end_q   <= 1'b0;
`ifdef LOAD_TIMEOUT_EN
      idle_q      <= '0;
      terr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      addr_q      <= addr_d;
      word_q      <= word_d;
      in_ready_q  <= in_ready_d;
      cs_n_q      <= cs_n_d;
      we_n_q      <= we_n_d;
      sram_addr_q <= sram_addr_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      clk_end_q   <= clk_end_d;
`ifdef LOAD_TIMEOUT_EN
      idle_q      <= idle_d;
      terr_q      <= terr_d;
`endif
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.sram_cs_n  = cs_n_q;
  assign bus.sram_we_n  = we_n_q;
  assign bus.sram_addr  = sram_addr_q;
  assign bus.sram_wdata = wdata_q;
  assign bus.busy       = busy_q;
  assign bus.load_done  = done_q;
  assign bus.clk_end    = clk_end_q;
`ifdef LOAD_TIMEOUT_EN
  assign bus.timeout_err = terr_q;
`endif

endmodule

// File: tb/tb_sram_write_ctrl.sv
// Scoreboard bench for sram_write_ctrl: random byte loads, reset abort,
// IDLE filtering and, with LOAD_TIMEOUT_EN, the stalled-load abort.
module tb_sram_write_ctrl;
  localparam int NW = 4;
  localparam int AW = 4;
  localparam int TO = 8;

  logic clk_i = 1'b0;
  logic rst   = 1'b1;
  always #5 clk_i = ~clk_i;

  sram_write_ctrl_if #(.ADDR_W(AW)) bus();

  sram_write_ctrl #(
    .NUM_WORDS(NW), .ADDR_W(AW), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk_i), .rst(rst), .bus(bus)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  int checks   = 0;
  int failures = 0;
  wr_t        exp_wr[$];
  logic [1:0] exp_ev[$];
  int         busy_runs[$];
  int         run_len = 0;
  logic [7:0] bytes[NW*4];

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // monitor: pops expectations whenever the DUT presents an event
  always @(negedge clk_i) begin
    if (rst) begin
      run_len = 0;
    end else begin
      if (!bus.sram_cs_n || !bus.sram_we_n) begin
        if (exp_wr.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_write addr=%h data=%h",
                   bus.sram_addr, bus.sram_wdata);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("wr_cs_n", 32'(bus.sram_cs_n), 0);
          chk("wr_we_n", 32'(bus.sram_we_n), 0);
          chk("wr_addr", 32'(bus.sram_addr), 32'(e.a));
          chk("wr_data", bus.sram_wdata, e.d);
        end
      end
      if (bus.load_done || bus.clk_end) begin
        if (exp_ev.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_event load_done=%0b clk_end=%0b",
                   bus.load_done, bus.clk_end);
        end else begin
          logic [1:0] ev;
          ev = exp_ev.pop_front();
          chk("load_done", 32'(bus.load_done), 32'(ev[1]));
          chk("clk_end", 32'(bus.clk_end), 32'(ev[0]));
        end
      end
      if (bus.busy) begin
        run_len++;
      end else if (run_len > 0) begin
        busy_runs.push_back(run_len);
        run_len = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_start();
    bus.start_in = 1'b1;
    cyc();
    bus.start_in = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input int gap);
    bit ok, rdy;
    ok = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int i = 0; i < 40 && !ok; i++) begin
      rdy = bus.in_ready;
      cyc();
      if (rdy) ok = 1;
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL byte_accept actual=stalled required=accepted");
    end
    if (gap > 0) begin
      bus.in_valid = 1'b0;
      repeat (gap) cyc();
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && bus.busy; i++) cyc();
    chk("return_idle", 32'(bus.busy), 0);
  endtask

  // full load of bytes[]; expected words built by little-endian packing
  task automatic run_load(input int mingap, input int maxgap,
                          input int repulse);
    for (int w = 0; w < NW; w++) begin
      wr_t e;
      e.a = AW'(w);
      e.d = 0;
      for (int k = 0; k < 4; k++)
        e.d = e.d + (32'(bytes[4*w+k]) << (8*k));
      exp_wr.push_back(e);
    end
    exp_ev.push_back(2'b11);
    pulse_start();
    chk("start_latency", 32'(bus.in_ready), 1);
    for (int i = 0; i < NW*4; i++) begin
      send_byte(bytes[i], int'($urandom_range(maxgap, mingap)));
      if (i == repulse) begin
        bus.in_valid = 1'b0;
        pulse_start();
      end
    end
    bus.in_valid = 1'b0;
    wait_idle();
    repeat (2) cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bus.start_in = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_cs_n", 32'(bus.sram_cs_n), 1);
    chk("rst_we_n", 32'(bus.sram_we_n), 1);
    chk("rst_addr", 32'(bus.sram_addr), 0);
    chk("rst_wdata", bus.sram_wdata, 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_load_done", 32'(bus.load_done), 0);
    chk("rst_clk_end", 32'(bus.clk_end), 0);
    cyc();
    rst = 1'b0;
    cyc();

    // bytes offered in IDLE are not taken
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("idle_in_ready", 32'(bus.in_ready), 0);
      chk("idle_cs_n", 32'(bus.sram_cs_n), 1);
    end
    bus.in_valid = 1'b0;
    cyc();

    // streamed 0x00..0x0F with valid held high
    for (int i = 0; i < NW*4; i++) bytes[i] = 8'(i);
    busy_runs.delete();
    run_load(0, 0, -1);
    chk("busy_runs", 32'(busy_runs.size()), 1);
    if (busy_runs.size() > 0)
      chk("busy_cycles", 32'(busy_runs[$]), 21);

    // 3-cycle gaps between bytes
    for (int i = 0; i < NW*4; i++) bytes[i] = 8'($urandom);
    bytes[0] = 8'hAA; bytes[1] = 8'hBB;
    bytes[2] = 8'hCC; bytes[3] = 8'hDD;
    run_load(3, 3, -1);

    // start re-pulsed mid-word is ignored
    for (int i = 0; i < NW*4; i++) bytes[i] = 8'($urandom);
    run_load(0, 2, 1);

    // reset after 6 bytes: only word 0 is written
    for (int i = 0; i < NW*4; i++) bytes[i] = 8'($urandom);
    begin
      wr_t e;
      e.a = '0;
      e.d = {bytes[3], bytes[2], bytes[1], bytes[0]};
      exp_wr.push_back(e);
    end
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(bytes[i], 0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_in_ready", 32'(bus.in_ready), 0);
    chk("arst_cs_n", 32'(bus.sram_cs_n), 1);
    chk("arst_addr", 32'(bus.sram_addr), 0);
    cyc();
    rst = 1'b0;
    repeat (3) cyc();
    chk("pre_reset_writes", 32'(exp_wr.size()), 0);
    for (int i = 0; i < NW*4; i++) bytes[i] = 8'($urandom);
    run_load(0, 1, -1);

`ifdef LOAD_TIMEOUT_EN
    // stalled load aborts with clk_end only
    exp_ev.push_back(2'b01);
    pulse_start();
    repeat (12) cyc();
    chk("timeout_err_set", 32'(bus.timeout_err), 1);
    chk("timeout_busy", 32'(bus.busy), 0);
    for (int i = 0; i < NW*4; i++) bytes[i] = 8'($urandom);
    run_load(0, 3, -1);
    chk("timeout_err_clr", 32'(bus.timeout_err), 0);
`endif

    // random loads
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < NW*4; i++) bytes[i] = 8'($urandom);
      run_load(0, int'($urandom_range(3, 0)),
               int'($urandom_range(NW*4 - 2, 0)));
    end

    repeat (5) cyc();
    chk("writes_drained", 32'(exp_wr.size()), 0);
    chk("events_drained", 32'(exp_ev.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sram_write_ctrl.md
SRAM_WRITE_CTRL -- requirements
Module: sram_write_ctrl

Interface
REQ-001 Parameter NUM_WORDS, default 16: number of 32-bit words written per load.
REQ-002 Parameter ADDR_W, default 4: SRAM address width; NUM_WORDS SHALL be at most 2**ADDR_W.
REQ-003 Parameter TIMEOUT, default 255: maximum idle cycles in LOAD, used only under LOAD_TIMEOUT_EN.
REQ-004 Ports SHALL be, in order:
- clk_i  in  1  clock, rising edge; one clock only.
- rst  in  1  asynchronous, active-high reset.
- start_in  in  1  one-cycle start pulse from the clock-gate stage.
- in_valid  in  1  input byte valid.
- in_data  in  8  input byte.
- in_ready  out  1  byte accepted when in_valid and in_ready are both high.
- sram_cs_n  out  1  SRAM chip select, active low.
- sram_we_n  out  1  SRAM write enable, active low.
- sram_addr  out  ADDR_W  word address.
- sram_wdata  out  32  write data.
- busy  out  1  high in every state except IDLE.
- load_done  out  1  one-cycle pulse after the last word is written.
- clk_end  out  1  one-cycle request to the clock-gate stage to stop the clock.
- timeout_err  out  1  sticky error; present only under LOAD_TIMEOUT_EN.

Function
REQ-005 FSM states SHALL be IDLE, LOAD, WRITE and DONE, with all outputs registered.
REQ-006 In IDLE, start_in=1 SHALL move the FSM to LOAD on the next edge, clearing byte_cnt and addr to 0.
REQ-007 start_in SHALL be ignored in LOAD, WRITE and DONE.
REQ-008 in_ready SHALL be 1 only in LOAD.
- Each accepted byte SHALL be stored in lane byte_cnt, little-endian: the first byte goes to bits 7:0.
- byte_cnt SHALL then increment by 1.
REQ-009 in_valid while in_ready=0 SHALL not consume data or change any state.
REQ-010 Acceptance of the 4th byte (byte_cnt=3) SHALL move the FSM to WRITE and reset byte_cnt to 0.
REQ-011 WRITE SHALL last exactly one cycle with sram_cs_n=0, sram_we_n=0, sram_addr=addr and sram_wdata=the packed word.
- At all other times sram_cs_n=1 and sram_we_n=1.
REQ-012 On leaving WRITE:
- if addr=NUM_WORDS-1, the FSM SHALL go to DONE;
- otherwise addr SHALL increment by 1 and the FSM SHALL return to LOAD.
REQ-013 DONE SHALL last one cycle, with load_done=1 and clk_end=1, then go to IDLE.
REQ-014 Latency from the start_in edge to the first in_ready=1 SHALL be 1 cycle.
- Each word SHALL take at least 5 cycles: 4 LOAD cycles plus 1 WRITE cycle.
REQ-015 addr SHALL never wrap: the final word is written at NUM_WORDS-1, and the next load restarts at 0.

Reset
REQ-016 rst=1 SHALL force the following immediately, asynchronously, regardless of state (including mid-load):
- state=IDLE, byte_cnt=0, addr=0, packed word=0;
- in_ready=0, sram_cs_n=1, sram_we_n=1, sram_addr=0, sram_wdata=0;
- busy=0, load_done=0, clk_end=0, timeout_err=0.
REQ-017 An interrupted load SHALL be discarded: no partial word is written, and no load_done or clk_end pulse is issued.

Configuration
REQ-018 Macro LOAD_TIMEOUT_EN defined:
- A counter SHALL count consecutive LOAD cycles without an accepted byte, and clear on each acceptance.
- When the counter reaches TIMEOUT, the FSM SHALL abort to IDLE, pulse clk_end for one cycle with no load_done pulse, and set timeout_err=1.
- timeout_err SHALL clear when start_in is accepted in IDLE.
REQ-019 Macro LOAD_TIMEOUT_EN undefined:
- No counter and no timeout_err port SHALL exist.
- LOAD SHALL wait indefinitely.

Verification
REQ-020 NUM_WORDS=4; start_in pulse, then bytes 0x00..0x0F streamed with in_valid held high -> 4 write strobes:
- addr 0..3 with data 0x03020100, 0x07060504, 0x0B0A0908 and 0x0F0E0D0C;
- then load_done=1 and clk_end=1 for exactly 1 cycle;
- busy for 21 cycles.
REQ-021 Bytes 0xAA, 0xBB, 0xCC, 0xDD with a 3-cycle in_valid gap after each byte -> a single write at addr 0 with data 0xDDCCBBAA.
REQ-022 start_in re-pulsed during LOAD at byte_cnt=2 -> no change to addr, byte_cnt or data.
REQ-023 rst asserted for 1 cycle after 6 bytes, then a full load -> no write at addr 1 before reset; after reset, writes start again at addr 0.
REQ-024 LOAD_TIMEOUT_EN with TIMEOUT=8; in_valid low for 8 cycles in LOAD:
- clk_end pulses once, load_done stays 0, timeout_err=1;
- the next start_in clears timeout_err.
REQ-025 in_valid=1 with in_data=0x55 held in IDLE for 10 cycles -> in_ready=0 and no SRAM strobe.
